// File: rtl/dnn_pkg.sv
// Shared types and default sizing for the DNN result selector.
package dnn_pkg;
  localparam int DEF_DATA_WIDTH  = 3;
  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_IDX_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } dnn_state_t;
endpackage

// File: rtl/dnn_argmax_step.sv
// Running argmax: one candidate per enabled cycle, strict signed greater-than so ties keep the lower index.
// o_next_idx is the winner including the current candidate (combinational), state updates on the clock.
module dnn_argmax_step
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clr,
  input  logic                         i_en,
  input  logic                         i_first,
  input  logic signed [DATA_WIDTH-1:0] i_cand_val,
  input  logic        [IDX_WIDTH-1:0]  i_cand_idx,
  output logic        [IDX_WIDTH-1:0]  o_next_idx
);
  logic signed [DATA_WIDTH-1:0] r_best_val;
  logic        [IDX_WIDTH-1:0]  r_best_idx;
  logic                         w_take;

  // First candidate loads unconditionally; afterwards only a strictly larger score wins.
  assign w_take     = i_first || (i_cand_val > r_best_val);
  assign o_next_idx = w_take ? i_cand_idx : r_best_idx;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_best_val <= '0;
      r_best_idx <= '0;
    end else if (i_en && w_take) begin
      r_best_val <= i_cand_val;
      r_best_idx <= i_cand_idx;
    end
  end
endmodule

// File: rtl/dnn_result_sel.sv
// Captures class scores on a done edge, scans them for the argmax over NUM_CLASSES cycles,
// and serves registered 1-cycle reads of the captured bank at any time.
module dnn_result_sel
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int IDX_WIDTH   = DEF_IDX_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] scores_in,
  input  logic                                   scores_done,
  input  logic                                   clear,
  input  logic                                   rd_en,
  input  logic [IDX_WIDTH-1:0]                   rd_idx,
  output logic signed [DATA_WIDTH-1:0]           rd_data,
  output logic                                   rd_valid,
  output logic                                   rd_err,
  output logic [IDX_WIDTH-1:0]                   class_id,
  output logic                                   class_valid,
  output logic                                   busy,
  output logic                                   overrun
);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [IDX_WIDTH:0]   NUM_EXT  = (IDX_WIDTH + 1)'(NUM_CLASSES);

  dnn_state_t                   r_state, w_state_nxt;
  logic                         r_done_q;
  logic [IDX_WIDTH-1:0]         r_cnt;
  logic signed [DATA_WIDTH-1:0] r_bank [NUM_CLASSES];
  logic                         w_done_edge, w_capture, w_scan_step, w_last;
  logic [IDX_WIDTH-1:0]         w_next_idx;

  assign w_done_edge = scores_done && !r_done_q;
  assign busy        = (r_state == SCAN);

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_scan_step = 1'b0;
    w_last      = 1'b0;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (w_done_edge) begin
            w_capture   = 1'b1;
            w_state_nxt = SCAN;
          end
        end
        SCAN: begin
          w_scan_step = 1'b1;
          if (r_cnt == LAST_IDX) begin
            w_last      = 1'b1;
            w_state_nxt = HOLD;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_done_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_done_q <= scores_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (w_capture) begin
      r_cnt <= '0;
    end else if (w_scan_step) begin
      r_cnt <= r_cnt + IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (rst || clear) begin
        r_bank[i] <= '0;
      end else if (w_capture) begin
        r_bank[i] <= scores_in[i];
      end
    end
  end

  dnn_argmax_step #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (clear),
    .i_en      (w_scan_step),
    .i_first   (r_cnt == '0),
    .i_cand_val(r_bank[r_cnt]),
    .i_cand_idx(r_cnt),
    .o_next_idx(w_next_idx)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      class_id    <= '0;
      class_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (w_capture) begin
        class_valid <= 1'b0;
      end else if (w_last) begin
        class_id    <= w_next_idx;
        class_valid <= 1'b1;
      end
      // An edge mid-scan is dropped, only flagged.
      if (w_done_edge && r_state == SCAN) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else if (rd_en) begin
      rd_valid <= 1'b1;
      if ({1'b0, rd_idx} < NUM_EXT) begin
        rd_data <= r_bank[rd_idx];
        rd_err  <= 1'b0;
      end else begin
        rd_data <= '0;
        rd_err  <= 1'b1;
      end
    end else begin
      rd_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dnn_result_sel.sv
// Randomized and directed checks of dnn_result_sel against a transaction-level score/argmax model.
module tb_dnn_result_sel;
  localparam int DW = 3;
  localparam int NC = 10;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, scores_done, clear, rd_en;
  logic [IW-1:0]           rd_idx;
  logic [NC-1:0][DW-1:0]   scores_in;
  logic signed [DW-1:0]    rd_data;
  logic                    rd_valid, rd_err, class_valid, busy, overrun;
  logic [IW-1:0]           class_id;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [DW-1:0] m_bank [NC];
  logic signed [DW-1:0] m_rd_data;
  logic                 m_rd_valid, m_rd_err;

  dnn_result_sel #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .scores_in(scores_in), .scores_done(scores_done),
    .clear(clear), .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err), .class_id(class_id),
    .class_valid(class_valid), .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lowest index holding the maximum signed score.
  function automatic int ref_argmax();
    int best = 0;
    for (int k = 1; k < NC; k++)
      if (m_bank[k] > m_bank[best]) best = k;
    return best;
  endfunction

  // One clock; read-port expectation is formed from the bank as it stood before this edge.
  task automatic clk_step();
    if (rst) begin
      m_rd_valid = 1'b0; m_rd_data = '0; m_rd_err = 1'b0;
    end else if (rd_en) begin
      m_rd_valid = 1'b1;
      if (int'(rd_idx) < NC) begin
        m_rd_data = m_bank[rd_idx]; m_rd_err = 1'b0;
      end else begin
        m_rd_data = '0; m_rd_err = 1'b1;
      end
    end else begin
      m_rd_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("rd_valid", rd_valid, m_rd_valid);
    chk("rd_data", rd_data, m_rd_data);
    chk("rd_err", rd_err, m_rd_err);
  endtask

  task automatic rand_scores();
    for (int i = 0; i < NC; i++) scores_in[i] = DW'($urandom_range(0, 7));
  endtask

  task automatic model_capture();
    for (int i = 0; i < NC; i++) m_bank[i] = scores_in[i];
  endtask

  task automatic model_zero();
    for (int i = 0; i < NC; i++) m_bank[i] = '0;
  endtask

  // Waits (bounded) for class_valid, checking busy each cycle; lat is the current cycle after the edge.
  task automatic finish_scan(input string tag, input int lat_in);
    int lat = lat_in;
    while (class_valid !== 1'b1 && lat < 40) begin
      chk({tag, "_busy"}, busy, 1'b1);
      rd_en  = 1'($urandom_range(0, 1));
      rd_idx = IW'($urandom_range(0, 15));
      rand_scores();
      clk_step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 11);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_class"}, class_id, ref_argmax());
  endtask

  task automatic edge_and_scan(input string tag);
    scores_done = 1'b1;
    clk_step();
    model_capture();
    finish_scan(tag, 1);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < NC; i++) begin
      rd_en = 1'b1; rd_idx = IW'(i);
      clk_step();
    end
    rd_en = 1'b0;
    clk_step();
    chk({tag, "_rdv_low"}, rd_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    int init_s [NC] = '{0, 1, 3, -2, 3, -4, 2, 0, 1, -1};
    rst = 1'b1; scores_done = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_idx = '0; scores_in = '0;
    model_zero();
    m_rd_data = '0; m_rd_valid = 1'b0; m_rd_err = 1'b0;
    clk_step(); clk_step();
    chk("rst_class_id", class_id, 0);
    chk("rst_class_valid", class_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    clk_step();

    // Tie between indices 2 and 4 must resolve to 2; done stays high through the scan.
    for (int i = 0; i < NC; i++) scores_in[i] = DW'(init_s[i]);
    edge_and_scan("tie");
    chk("tie_idx_const", class_id, 2);
    chk("tie_overrun", overrun, 0);

    // Live scores change; reads must return the captured bank.
    for (int i = 0; i < NC; i++) scores_in[i] = DW'(-4);
    read_all("captured");
    rd_en = 1'b1; rd_idx = IW'(12);
    clk_step();
    chk("oor_err", rd_err, 1'b1);
    for (int j = 0; j < 4; j++) begin
      rd_idx = IW'($urandom_range(NC, 15));
      clk_step();
    end
    rd_en = 1'b0;
    clk_step();

    // Random captures from HOLD.
    for (int it = 0; it < 25; it++) begin
      scores_done = 1'b0;
      rand_scores();
      rd_en = 1'($urandom_range(0, 1)); rd_idx = IW'($urandom_range(0, 15));
      clk_step();
      edge_and_scan("rand");
    end

    // Second edge during SCAN: flagged, ignored.
    scores_done = 1'b0; rand_scores(); clk_step();
    scores_done = 1'b1; clk_step(); model_capture();
    scores_done = 1'b0;
    for (int c = 1; c < 5; c++) begin rand_scores(); clk_step(); end
    scores_done = 1'b1; rand_scores(); clk_step();
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_busy", busy, 1'b1);
    finish_scan("ovr", 6);
    chk("ovr_sticky", overrun, 1'b1);
    read_all("ovr_bank");
    clear = 1'b1; scores_done = 1'b0; clk_step(); model_zero(); clear = 1'b0;
    chk("clr_overrun", overrun, 1'b0);
    chk("clr_class_valid", class_valid, 1'b0);
    chk("clr_class_id", class_id, 0);
    read_all("clr_bank");

    // Clear coincident with a done edge wins: no capture.
    rand_scores(); edge_and_scan("pre_cc");
    scores_done = 1'b0; clk_step();
    rand_scores(); scores_done = 1'b1; clear = 1'b1;
    clk_step(); model_zero(); clear = 1'b0;
    chk("cc_busy", busy, 1'b0);
    chk("cc_class_valid", class_valid, 1'b0);
    clk_step();
    chk("cc_busy_after", busy, 1'b0);
    read_all("cc_bank");

    // Reset mid-scan aborts with no class_valid pulse.
    scores_done = 1'b0; rand_scores(); clk_step();
    scores_done = 1'b1; clk_step(); model_capture();
    clk_step(); clk_step(); clk_step();
    rst = 1'b1; scores_done = 1'b0; rd_en = 1'b1; rd_idx = IW'(1);
    clk_step(); model_zero();
    chk("rs_class_id", class_id, 0);
    chk("rs_class_valid", class_valid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_overrun", overrun, 0);
    rst = 1'b0; rd_en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      clk_step();
      chk("rs_no_cv", class_valid, 1'b0);
    end
    rand_scores();
    edge_and_scan("post_rst");
    read_all("post_rst_bank");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
